// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the multicycle MIPS control unit
package mips_pkg;

  // Sequencer states; codes 12-15 are unused and recover to S_FETCH
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC     = 4'd6,
    S_RWB      = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
  } estado_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU operand B: register B, constant 4, sign-extended imm, imm << 2
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_CUATRO = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // Next PC: ALU result, ALUOut register (branch target), jump address
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       excepcion;
  } control_t;

  function automatic logic opcode_valido(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/decodificador_salidas.sv
// rtl/decodificador_salidas.sv - combinational control word from the current state
module decodificador_salidas
  import mips_pkg::*;
(
  input  estado_t    estado,
  input  logic       mem_listo,
  input  logic [5:0] opcode,
  input  logic       rst_n,
  output control_t   ctrl
);

  // Moore decode of the state, with fetch strobes gated by memory ready
  // and the exception gated by the opcode; everything held low in reset
  always_comb begin
    ctrl = '0;
    if (rst_n) begin
      case (estado)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = SRCB_CUATRO;
          ctrl.alu_op    = ALUOP_ADD;
          ctrl.pc_source = PCSRC_ALU;
          ctrl.ir_write  = mem_listo;
          ctrl.pc_write  = mem_listo;
        end
        S_DECODE: begin
          ctrl.alu_src_b = SRCB_IMM_SH;
          ctrl.excepcion = !opcode_valido(opcode);
        end
        S_MEMADR, S_ADDI_EX: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        S_MEMREAD: begin
          ctrl.mem_read = 1'b1;
          ctrl.ior_d    = 1'b1;
        end
        S_MEMWB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
        end
        S_MEMWRITE: begin
          ctrl.mem_write = 1'b1;
          ctrl.ior_d     = 1'b1;
        end
        S_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_REG;
          ctrl.alu_op    = ALUOP_FUNCT;
        end
        S_RWB: begin
          ctrl.reg_write = 1'b1;
          ctrl.reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_op        = ALUOP_SUB;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_source     = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCSRC_JUMP;
        end
        S_ADDI_WB: begin
          ctrl.reg_write = 1'b1;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/control_multiciclo.sv
// rtl/control_multiciclo.sv - multicycle MIPS sequencer with retire counter
module control_multiciclo
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_listo,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        RegDst,
  output logic        Regwrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSource,
  output logic        excepcion,
  output logic [3:0]  estado,
  output logic [31:0] instr_completadas
);

  estado_t     estado_q;
  estado_t     estado_d;
  logic        retira;
  logic [31:0] contador;
  control_t    ctrl;

  // zero is consumed by the datapath together with PCWriteCond; the
  // sequencer itself never branches on it
  logic unused_zero;
  assign unused_zero = zero;

  // Next state and retire detection; opcode only matters in DECODE/MEMADR
  always_comb begin
    estado_d = estado_q;
    retira   = 1'b0;
    case (estado_q)
      S_FETCH:    if (mem_listo) estado_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:         estado_d = S_EXEC;
          OP_LW, OP_SW: estado_d = S_MEMADR;
          OP_BEQ:       estado_d = S_BRANCH;
          OP_J:         estado_d = S_JUMP;
          OP_ADDI:      estado_d = S_ADDI_EX;
          default:      estado_d = S_FETCH;
        endcase
      end
      S_MEMADR:   estado_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_listo) estado_d = S_MEMWB;
      S_MEMWRITE: begin
        if (mem_listo) begin
          estado_d = S_FETCH;
          retira   = 1'b1;
        end
      end
      S_EXEC:     estado_d = S_RWB;
      S_ADDI_EX:  estado_d = S_ADDI_WB;
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
        estado_d = S_FETCH;
        retira   = 1'b1;
      end
      default:    estado_d = S_FETCH;
    endcase
  end

  // State register and wrapping retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= S_FETCH;
      contador <= '0;
    end else begin
      estado_q <= estado_d;
      if (retira) contador <= contador + 32'd1;
    end
  end

  decodificador_salidas u_decodificador (
    .estado    (estado_q),
    .mem_listo (mem_listo),
    .opcode    (opcode),
    .rst_n     (rst_n),
    .ctrl      (ctrl)
  );

  assign PCWrite           = ctrl.pc_write;
  assign PCWriteCond       = ctrl.pc_write_cond;
  assign IorD              = ctrl.ior_d;
  assign MemRead           = ctrl.mem_read;
  assign MemWrite          = ctrl.mem_write;
  assign IRWrite           = ctrl.ir_write;
  assign MemtoReg          = ctrl.mem_to_reg;
  assign RegDst            = ctrl.reg_dst;
  assign Regwrite          = ctrl.reg_write;
  assign ALUSrcA           = ctrl.alu_src_a;
  assign ALUSrcB           = ctrl.alu_src_b;
  assign ALUOp             = ctrl.alu_op;
  assign PCSource          = ctrl.pc_source;
  assign excepcion         = ctrl.excepcion;
  assign estado            = estado_q;
  assign instr_completadas = contador;

endmodule

// File: tb/tb_control_multiciclo.sv
// tb/tb_control_multiciclo.sv - directed table and sequence bench for control_multiciclo
module tb_control_multiciclo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = 6'h3F;
  logic        zero = 1'b0;
  logic        mem_listo = 1'b1;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, Regwrite, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic        excepcion;
  logic [3:0]  estado;
  logic [31:0] instr_completadas;

  always #5 clk = ~clk;

  control_multiciclo dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_listo(mem_listo),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .Regwrite(Regwrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .excepcion(excepcion), .estado(estado),
    .instr_completadas(instr_completadas)
  );

  // {exc, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
  //  MemtoReg, RegDst, Regwrite, ALUSrcA, ALUSrcB, ALUOp, PCSource}
  localparam logic [16:0] W_NONE   = 17'h00000;
  localparam logic [16:0] W_FETCH  = 17'h09410;
  localparam logic [16:0] W_FWAIT  = 17'h01010;
  localparam logic [16:0] W_DEC    = 17'h00030;
  localparam logic [16:0] W_ADR    = 17'h00060;
  localparam logic [16:0] W_MWR    = 17'h02800;
  localparam logic [16:0] W_EXEC   = 17'h00048;
  localparam logic [16:0] W_RWB    = 17'h00180;
  localparam logic [16:0] W_JUMP   = 17'h08002;
  localparam logic [16:0] W_ADDIWB = 17'h00080;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        ml;
    logic [3:0]  est;
    logic [16:0] ctl;
    logic [31:0] cnt;
  } vec_t;

  vec_t tabla [18];
  int   n_chk = 0;
  int   n_fail = 0;
  int   r_cyc, r_rw, r_st3, r_mr3, r_pcw8, r_pcwc8, r_exc, r_both;

  function automatic logic [16:0] palabra();
    return {excepcion, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
            MemtoReg, RegDst, Regwrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
  endfunction

  task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nombre, act, exp);
    end
  endtask

  // Entered at a falling edge with the DUT in FETCH; runs one instruction,
  // holding mem_listo low for the first 'waits' cycles of a memory state
  task automatic run_instr(input logic [5:0] op, input logic z, input int waits);
    int  w;
    logic done;
    w = waits;
    done = 1'b0;
    r_cyc = 0; r_rw = 0; r_st3 = 0; r_mr3 = 0; r_pcw8 = 0; r_pcwc8 = 0; r_exc = 0; r_both = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      opcode = op;
      zero = z;
      mem_listo = ((estado == 4'd3 || estado == 4'd5) && w > 0) ? 1'b0 : 1'b1;
      if (!mem_listo) w--;
      #1;
      r_cyc++;
      if (Regwrite) r_rw++;
      if (Regwrite && MemWrite) r_both++;
      if (excepcion) r_exc++;
      if (estado == 4'd3) begin
        r_st3++;
        if (MemRead) r_mr3++;
      end
      if (estado == 4'd8 && PCWrite) r_pcw8++;
      if (estado == 4'd8 && PCWriteCond) r_pcwc8++;
      @(negedge clk);
      if (estado == 4'd0) done = 1'b1;
    end
    chk("instr_ends", {31'd0, done}, 32'd1);
    chk("rw_mw_exclusive", r_both, 0);
  endtask

  initial begin
    tabla[0]  = '{1'b0, 6'h3F, 1'b1, 4'd0,  W_NONE,   32'd0};
    tabla[1]  = '{1'b0, 6'h00, 1'b1, 4'd0,  W_NONE,   32'd0};
    tabla[2]  = '{1'b1, 6'h3F, 1'b1, 4'd0,  W_FETCH,  32'd0};
    tabla[3]  = '{1'b1, 6'h00, 1'b1, 4'd1,  W_DEC,    32'd0};
    tabla[4]  = '{1'b1, 6'h3F, 1'b1, 4'd6,  W_EXEC,   32'd0};
    tabla[5]  = '{1'b1, 6'h3F, 1'b1, 4'd7,  W_RWB,    32'd0};
    tabla[6]  = '{1'b1, 6'h3F, 1'b0, 4'd0,  W_FWAIT,  32'd1};
    tabla[7]  = '{1'b1, 6'h3F, 1'b1, 4'd0,  W_FETCH,  32'd1};
    tabla[8]  = '{1'b1, 6'h08, 1'b1, 4'd1,  W_DEC,    32'd1};
    tabla[9]  = '{1'b1, 6'h3F, 1'b1, 4'd10, W_ADR,    32'd1};
    tabla[10] = '{1'b1, 6'h3F, 1'b1, 4'd11, W_ADDIWB, 32'd1};
    tabla[11] = '{1'b1, 6'h3F, 1'b1, 4'd0,  W_FETCH,  32'd2};
    tabla[12] = '{1'b1, 6'h2B, 1'b1, 4'd1,  W_DEC,    32'd2};
    tabla[13] = '{1'b1, 6'h2B, 1'b1, 4'd2,  W_ADR,    32'd2};
    tabla[14] = '{1'b1, 6'h3F, 1'b1, 4'd5,  W_MWR,    32'd2};
    tabla[15] = '{1'b1, 6'h3F, 1'b1, 4'd0,  W_FETCH,  32'd3};
    tabla[16] = '{1'b1, 6'h02, 1'b1, 4'd1,  W_DEC,    32'd3};
    tabla[17] = '{1'b1, 6'h3F, 1'b1, 4'd9,  W_JUMP,   32'd3};

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      rst_n = tabla[i].rst;
      opcode = tabla[i].op;
      mem_listo = tabla[i].ml;
      #1;
      chk($sformatf("estado[%0d]", i), {28'd0, estado}, {28'd0, tabla[i].est});
      chk($sformatf("ctrl[%0d]", i), {15'd0, palabra()}, {15'd0, tabla[i].ctl});
      chk($sformatf("cnt[%0d]", i), instr_completadas, tabla[i].cnt);
    end
    @(negedge clk);

    // lw with three memory wait cycles
    run_instr(6'b100011, 1'b0, 3);
    chk("lw_cycles", r_cyc, 8);
    chk("lw_memread_cycles", r_st3, 4);
    chk("lw_memread_high", r_mr3, 4);
    chk("lw_regwrite", r_rw, 1);
    chk("lw_cnt", instr_completadas, 32'd5);

    // sw with two memory wait cycles
    run_instr(6'b101011, 1'b0, 2);
    chk("sw_cycles", r_cyc, 6);
    chk("sw_regwrite", r_rw, 0);
    chk("sw_cnt", instr_completadas, 32'd6);

    // beq not taken, then taken
    for (int k = 0; k < 2; k++) begin
      run_instr(6'b000100, k[0], 0);
      chk($sformatf("beq%0d_cycles", k), r_cyc, 3);
      chk($sformatf("beq%0d_pcwritecond", k), r_pcwc8, 1);
      chk($sformatf("beq%0d_pcwrite", k), r_pcw8, 0);
      chk($sformatf("beq%0d_cnt", k), instr_completadas, 32'd7 + k);
    end

    // unsupported opcode
    run_instr(6'b111111, 1'b0, 0);
    chk("ill_cycles", r_cyc, 2);
    chk("ill_excepcion", r_exc, 1);
    chk("ill_cnt", instr_completadas, 32'd8);

    run_instr(6'b001000, 1'b0, 0);
    chk("addi_cycles", r_cyc, 4);
    chk("addi_regwrite", r_rw, 1);
    chk("addi_excepcion", r_exc, 0);
    chk("addi_cnt", instr_completadas, 32'd9);

    // reset during a MEMWRITE memory wait
    opcode = 6'b101011; mem_listo = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    mem_listo = 1'b0;
    #1;
    chk("mw_wait_estado", {28'd0, estado}, 32'd5);
    chk("mw_wait_memwrite", {31'd0, MemWrite}, 32'd1);
    @(negedge clk);
    mem_listo = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("abort_ctrl", {15'd0, palabra()}, 32'd0);
    chk("abort_estado", {28'd0, estado}, 32'd0);
    chk("abort_cnt", instr_completadas, 32'd0);
    @(negedge clk);
    #1;
    chk("abort_hold_memwrite", {31'd0, MemWrite}, 32'd0);
    chk("abort_hold_estado", {28'd0, estado}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    opcode = 6'h3F;
    mem_listo = 1'b1;

    // counter wrap on a retiring jump
    @(negedge clk);
    opcode = 6'b000010;
    @(negedge clk);
    force dut.contador = 32'hFFFF_FFFF;
    #1;
    release dut.contador;
    chk("wrap_jump_estado", {28'd0, estado}, 32'd9);
    @(negedge clk);
    #1;
    chk("wrap_cnt", instr_completadas, 32'd0);
    chk("wrap_estado", {28'd0, estado}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
